// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
// Holds the FSM state encoding, the per-transfer mode pair and the frame edge-count helper.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int unsigned edge_count(input int unsigned data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period timer for SCLK generation.
// Counts 0..CLK_DIV-1 while enabled and fires tick on the terminal count.
module spi_sclk_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: ready/start word handshake, run-time CPOL/CPHA,
// configurable width, SCLK divider and bit order. All outputs are registered.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  output logic              ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              SPI_MISO,
  output logic              SPI_MOSI,
  output logic              SPI_CLK,
  output logic              SPI_EN
);

  localparam int unsigned EDGES = edge_count(DATA_W);
  localparam int unsigned EW    = $clog2(EDGES + 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EW-1:0]     edge_q, edge_d, edge_n;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              en_q, en_d;
  logic              ready_q, ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tick, sample, drive;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  spi_sclk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .clr (state_q == IDLE),
    .tick(tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    en_d       = en_q;
    ready_d    = ready_q;
    rx_valid_d = 1'b0;
    // edge_n is the edge this tick produces; odd edges are the leading ones
    edge_n     = edge_q + 1'b1;
    sample     = mode_q.cpha ? ~edge_n[0] : edge_n[0];
    drive      = mode_q.cpha ? edge_n[0] : (~edge_n[0] && (edge_n != EW'(EDGES)));

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start) begin
          state_d = LEAD;
          mode_d  = '{cpol: cpol, cpha: cpha};
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          edge_d  = '0;
          en_d    = 1'b1;
          ready_d = 1'b0;
          if (!cpha) begin
            mosi_d  = first_bit(tx_data);
            tx_sh_d = advance(tx_data);
          end
        end
      end
      // The LEAD terminal tick already produces edge 1, so LEAD and XFER share the edge logic
      LEAD, XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_n;
          if (sample) begin
            rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], SPI_MISO}
                                : {SPI_MISO, rx_sh_q[DATA_W-1:1]};
          end
          if (drive) begin
            mosi_d  = first_bit(tx_sh_q);
            tx_sh_d = advance(tx_sh_q);
          end
          state_d = (edge_n == EW'(EDGES)) ? TRAIL : XFER;
        end
      end
      TRAIL: begin
        sclk_d = mode_q.cpol;
        if (tick) begin
          state_d    = IDLE;
          en_d       = 1'b0;
          ready_d    = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      en_q       <= 1'b0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign ready    = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_EN   = en_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param across three parameter sets.
// Expected words and completion cycles are queued on accept and retired on rx_valid.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // A: DATA_W=8, CLK_DIV=2, MSB first
  logic       a_start, a_cpol, a_cpha, a_ready, a_rxv, a_miso, a_mosi, a_sclk, a_en;
  logic [7:0] a_tx, a_rx;
  // B: DATA_W=16, CLK_DIV=1, LSB first
  logic        b_start, b_cpol, b_cpha, b_ready, b_rxv, b_miso, b_mosi, b_sclk, b_en;
  logic [15:0] b_tx, b_rx;
  // C: DATA_W=8, CLK_DIV=4, MSB first
  logic       c_start, c_cpol, c_cpha, c_ready, c_rxv, c_miso, c_mosi, c_sclk, c_en;
  logic [7:0] c_tx, c_rx;

  logic        a_loop;
  logic [7:0]  a_slave;
  logic [7:0]  a_mosi_cap;
  logic        a_prev_sclk;
  int unsigned a_edges;
  logic [2:0]  a_sidx;

  // Mode-0 slave: bit j is presented until the trailing edge that follows its sample
  always_comb a_sidx = 3'd7 - 3'(a_edges >> 1);
  assign a_miso = a_loop ? a_mosi : a_slave[a_sidx];
  assign b_miso = b_mosi;
  assign c_miso = c_mosi;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .cpol(a_cpol), .cpha(a_cpha),
    .ready(a_ready), .rx_data(a_rx), .rx_valid(a_rxv),
    .SPI_MISO(a_miso), .SPI_MOSI(a_mosi), .SPI_CLK(a_sclk), .SPI_EN(a_en));

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .cpol(b_cpol), .cpha(b_cpha),
    .ready(b_ready), .rx_data(b_rx), .rx_valid(b_rxv),
    .SPI_MISO(b_miso), .SPI_MOSI(b_mosi), .SPI_CLK(b_sclk), .SPI_EN(b_en));

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .tx_data(c_tx), .cpol(c_cpol), .cpha(c_cpha),
    .ready(c_ready), .rx_data(c_rx), .rx_valid(c_rxv),
    .SPI_MISO(c_miso), .SPI_MOSI(c_mosi), .SPI_CLK(c_sclk), .SPI_EN(c_en));

  typedef struct {
    int unsigned id;
    logic [31:0] data;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sb_pop(input int unsigned id, input logic [31:0] rx);
    exp_t e;
    if (sb.size() == 0 || sb[0].id != id) begin
      chk($sformatf("rxv_unexpected_%0d", id), 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("rx_data_%0d", id), rx, e.data);
      chk($sformatf("rx_cycle_%0d", id), cyc, e.due);
    end
  endtask

  // Retire completions first, then queue accepts seen in the same cycle
  always @(negedge clk) begin
    if (a_rxv) sb_pop(0, 32'(a_rx));
    if (b_rxv) sb_pop(1, 32'(b_rx));
    if (c_rxv) sb_pop(2, 32'(c_rx));
    if (!rst) begin
      if (a_start && a_ready) sb.push_back('{id: 0, data: 32'(a_loop ? a_tx : a_slave), due: cyc + 35});
      if (b_start && b_ready) sb.push_back('{id: 1, data: 32'(b_tx), due: cyc + 34});
      if (c_start && c_ready) sb.push_back('{id: 2, data: 32'(c_tx), due: cyc + 69});
    end
    if (a_en) begin
      if (a_sclk != a_prev_sclk) begin
        a_edges++;
        if (a_sclk) a_mosi_cap = {a_mosi_cap[6:0], a_mosi};
      end
    end else begin
      a_edges    = 0;
      a_mosi_cap = '0;
    end
    a_prev_sclk = a_sclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rxv(input int id, input int budget);
    int   k;
    logic v;
    k = 0;
    v = 1'b0;
    while (!v && k < budget) begin
      @(negedge clk);
      v = (id == 0) ? a_rxv : (id == 1) ? b_rxv : c_rxv;
      k++;
    end
    if (!v) chk($sformatf("rxv_timeout_%0d", id), 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic exp_cpol;
    int   run;
    logic prev;
    rst = 1'b1;
    a_start = 0; a_tx = '0; a_cpol = 1; a_cpha = 0;
    b_start = 0; b_tx = '0; b_cpol = 1; b_cpha = 0;
    c_start = 0; c_tx = '0; c_cpol = 0; c_cpha = 0;
    a_loop = 1; a_slave = '0; a_edges = 0; a_mosi_cap = '0; a_prev_sclk = 0;

    // Reset state; live cpol=1 must not leak onto SCLK while reset is held
    step(3);
    @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_rx_data", 32'(a_rx), 32'd0);
    chk("rst_rx_valid", 32'(a_rxv), 32'd0);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    chk("rst_en", 32'(a_en), 32'd0);
    chk("rst_sclk", 32'(a_sclk), 32'd0);
    chk("rst_sclk_b", 32'(b_sclk), 32'd0);
    chk("rst_ready_c", 32'(c_ready), 32'd1);
    step(1);
    rst = 1'b0; a_cpol = 0; b_cpol = 0;
    step(2);

    // Mode 0, slave returns 0x3C, tx 0xA5
    a_loop = 0; a_slave = 8'h3C; a_tx = 8'hA5; a_cpol = 0; a_cpha = 0; a_start = 1;
    step(1);
    a_start = 0;
    @(negedge clk);
    chk("m0_en_c1", 32'(a_en), 32'd1);
    chk("m0_mosi_c1", 32'(a_mosi), 32'd1);
    chk("m0_sclk_c1", 32'(a_sclk), 32'd0);
    step(4);
    a_start = 1;
    step(1);
    a_start = 0;
    step(28);
    @(negedge clk);
    chk("m0_en_c34", 32'(a_en), 32'd1);
    chk("m0_mosi_bits", 32'(a_mosi_cap), 32'hA5);
    step(1);
    @(negedge clk);
    chk("m0_en_c35", 32'(a_en), 32'd0);
    chk("m0_rxv_c35", 32'(a_rxv), 32'd1);
    chk("m0_ready_c35", 32'(a_ready), 32'd1);
    a_loop = 1;

    // All four modes in loopback, with mode/data inputs disturbed mid-frame
    for (int m = 0; m < 4; m++) begin
      exp_cpol = (m >= 2);
      step(1);
      a_cpol = exp_cpol; a_cpha = (m % 2 == 1);
      step(2);
      @(negedge clk);
      chk($sformatf("idle_pre_m%0d", m), 32'(a_sclk), 32'(exp_cpol));
      step(1);
      a_tx = 8'h81; a_start = 1;
      step(1);
      a_start = 0;
      @(negedge clk);
      chk($sformatf("sclk_c1_m%0d", m), 32'(a_sclk), 32'(exp_cpol));
      step(2);
      a_tx = 8'h00; a_cpol = ~a_cpol; a_cpha = ~a_cpha;
      step(6);
      a_cpol = exp_cpol; a_cpha = (m % 2 == 1);
      wait_rxv(0, 60);
      step(2);
      @(negedge clk);
      chk($sformatf("idle_post_m%0d", m), 32'(a_sclk), 32'(exp_cpol));
    end

    // B: LSB first, 16 bit, CLK_DIV=1
    step(1);
    b_tx = 16'h0001; b_cpol = 0; b_cpha = 0; b_start = 1;
    step(1);
    b_start = 0;
    @(negedge clk);
    chk("b_mosi_c1", 32'(b_mosi), 32'd1);
    chk("b_en_c1", 32'(b_en), 32'd1);
    wait_rxv(1, 60);
    step(1);
    b_tx = 16'hBEEF; b_cpol = 1; b_cpha = 1; b_start = 1;
    step(1);
    b_start = 0;
    wait_rxv(1, 60);

    // Back-to-back with start held; tx changed mid-frame selects the second word
    step(2);
    a_cpol = 0; a_cpha = 1; a_tx = 8'h3C; a_start = 1;
    step(1);
    a_tx = 8'hC3;
    wait_rxv(0, 60);
    chk("b2b_en_gap", 32'(a_en), 32'd0);
    chk("b2b_ready_gap", 32'(a_ready), 32'd1);
    step(1);
    a_start = 0;
    @(negedge clk);
    chk("b2b_en_restart", 32'(a_en), 32'd1);
    chk("b2b_ready_busy", 32'(a_ready), 32'd0);
    wait_rxv(0, 60);
    step(40);

    // Reset at cycle 10 of a mode-3 frame
    a_cpol = 1; a_cpha = 1; a_tx = 8'h96; a_start = 1;
    step(1);
    a_start = 0;
    step(9);
    rst = 1'b1;
    sb.delete();
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(a_en), 32'd0);
    chk("abort_sclk", 32'(a_sclk), 32'd0);
    chk("abort_ready", 32'(a_ready), 32'd1);
    chk("abort_rxv", 32'(a_rxv), 32'd0);
    step(60);
    a_tx = 8'h96; a_start = 1;
    step(1);
    a_start = 0;
    wait_rxv(0, 60);

    // C: SCLK half-period widths with CLK_DIV=4
    step(2);
    c_tx = 8'h5A; c_cpol = 0; c_cpha = 0; c_start = 1;
    step(1);
    c_start = 0;
    run  = 0;
    prev = 1'b0;
    for (int n = 1; n <= 68; n++) begin
      if (n > 1) @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        prev = c_sclk;
        run  = 1;
      end else if (c_sclk != prev) begin
        chk($sformatf("c_width_n%0d", n), 32'(run), 32'd4);
        prev = c_sclk;
        run  = 1;
      end else begin
        run++;
      end
    end
    wait_rxv(2, 10);

    step(5);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master and next-generation SPI driver for the design. Supports configurable word width, SCLK divider and bit order. CPOL/CPHA mode is selectable per transfer at run time. A ready/start handshake accepts words, and a one-cycle rx_valid strobe returns the received word. It sits between a local controller (register bank or sequencer) and one off-chip SPI slave.

Parameters:
DATA_W, 8, bits per transfer; legal range 2..32.
CLK_DIV, 2, system clocks per SCLK half-period; legal range >= 1.
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first; applies to both MOSI and MISO.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  transfer request; accepted only in a cycle where ready=1.
tx_data  input  DATA_W  word to send; captured on accept.
cpol  input  1  SCLK idle level; captured on accept.
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; captured on accept.
ready  output  1  block idle and able to accept start.
rx_data  output  DATA_W  last received word; holds until the next completion.
rx_valid  output  1  one-cycle pulse when rx_data updates.
SPI_MISO  input  1  serial data from slave.
SPI_MOSI  output  1  serial data to slave.
SPI_CLK  output  1  serial clock.
SPI_EN  output  1  active-high slave enable, asserted for the whole frame.

Behaviour:
- Reset values: ready=1, rx_data=0, rx_valid=0, SPI_MOSI=0, SPI_CLK=0, SPI_EN=0, state IDLE, all counters 0.
- Reset takes effect on any cycle, including mid-frame. It aborts the frame with no rx_valid. SPI_CLK returns to 0 even if the captured cpol was 1.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE. ready=1 only in IDLE.
- Half-period tick: a counter runs 0..CLK_DIV-1 in LEAD/XFER/TRAIL. The tick fires when the count equals CLK_DIV-1, then the counter wraps to 0.
- Accept (cycle 0): IDLE and start=1. Capture tx_data, cpol and cpha into the shift register and mode registers.
- Cycle 1 onward:
  - SPI_EN=1 and SPI_CLK=captured cpol.
  - With cpha=0, SPI_MOSI presents the first bit at cycle 1.
  - With cpha=1, SPI_MOSI is driven on the first edge.
- In IDLE, SPI_CLK follows the live cpol input, so the idle level is correct before EN asserts.
- LEAD lasts CLK_DIV cycles; then go to XFER.
- XFER: each tick toggles SPI_CLK. There are exactly 2*DATA_W edges, and SCLK edge k becomes visible at cycle k*CLK_DIV+1.
  - cpha=0: odd (leading) edges sample SPI_MISO into the rx shift register; even (trailing) edges, except the last, shift the next bit onto MOSI.
  - cpha=1: odd edges drive the next bit onto MOSI; even edges sample MISO.
- After edge 2*DATA_W, SPI_CLK equals cpol. TRAIL lasts CLK_DIV cycles.
- At cycle (2*DATA_W+1)*CLK_DIV+1: SPI_EN=0, rx_valid=1, rx_data=assembled word, ready=1, state IDLE.
- SPI_MOSI holds its last value between frames.
- Bit order:
  - MSB_FIRST=1: MOSI sends bit DATA_W-1 first; the first MISO bit lands in rx bit DATA_W-1.
  - MSB_FIRST=0: mirrored.
- Simultaneous events:
  - start while busy is ignored, with no queueing.
  - start in the completion cycle (ready=1) is accepted. SPI_EN is then low for exactly one cycle between frames.
- cpol/cpha/tx_data changes during a frame have no effect.
- rx_valid never asserts for two consecutive cycles.

Decomposition:
- Package spi_pkg:
  - typedef enum spi_state_e {IDLE, LEAD, XFER, TRAIL};
  - typedef struct spi_mode_t {cpol, cpha};
  - shared constant helpers for edge count (2*DATA_W).
- One sub-module: spi_sclk_tick. It holds the CLK_DIV half-period counter, with enable/clear inputs and a tick output.
- Shift registers and the FSM stay in the top module.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, MSB_FIRST=1: tx_data=0xA5, slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; rx_valid at cycle 35 with rx_data=0x3C; SPI_EN high cycles 1..34.
- All four cpol/cpha modes, tx_data=0x81, loopback MISO=MOSI -> rx_data=0x81 each time; SPI_CLK idle level equals cpol before and after each frame.
- MSB_FIRST=0, DATA_W=16, CLK_DIV=1: tx_data=0x0001 -> first MOSI bit 1; rx_valid at cycle 34.
- Back-to-back: start held high continuously -> second accept in the rx_valid cycle; SPI_EN low exactly one cycle; start pulses during busy are ignored.
- Reset at cycle 10 of a mode-3 frame -> next cycle SPI_EN=0, SPI_CLK=0, ready=1, no rx_valid; a fresh frame afterwards completes correctly.
- CLK_DIV=4: measure SCLK high and low widths = 4 cycles each; rx_valid at (2*8+1)*4+1 = 69.
